// File: rtl/mult_bcd_conv.sv
// mult_bcd_conv: sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Takes the W-bit product from the multiplier and produces D packed BCD digits
// for the 7-segment stage, using a start/busy/done handshake.
// Optional build macro BCD_SIGNED_EN: bin_in is treated as two's complement, the
// magnitude is converted and the sign is reported on the extra output 'neg'.
module mult_bcd_conv #(
   parameter int unsigned W = 8,
   parameter int unsigned D = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   bin_in,
   output logic           busy,
   output logic           done,
   output logic [4*D-1:0] bcd_out,
   output logic           overflow
`ifdef BCD_SIGNED_EN
   ,
   output logic           neg
`endif
);

   localparam int unsigned BW = 4 * D;
   localparam int unsigned CW = $clog2(W + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [BW+W-1:0]  sr;
   logic [CW-1:0]    cnt;
   logic             ovf;
   logic [W-1:0]     load_val;
   logic [BW-1:0]    adj;
   logic [BW+W-1:0]  sr_shl;
   logic             last;

`ifdef BCD_SIGNED_EN
   logic             neg_cap;

   // Magnitude of the two's complement input; -2^(W-1) maps to 2^(W-1), which
   // still fits in W unsigned bits.
   always_comb begin
      load_val = bin_in;
      if (bin_in[W-1])
         load_val = (~bin_in) + W'(1);
   end
`else
   assign load_val = bin_in;
`endif

   assign last = (cnt == CW'(1));

   // Add-3 correction of every digit >= 5, then shift the whole register left.
   always_comb begin
      adj = sr[BW+W-1:W];
      for (int unsigned i = 0; i < D; i++) begin
         if (adj[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      sr_shl = {adj[BW-2:0], sr[W-1:0], 1'b0};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic and handshake outputs decoded from the state.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)
               state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (last)
               state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: capture on accept, shift while converting, publish on the last shift.
   // Any 1 leaving the top digit means the value has reached 10^D.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr       <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         bcd_out  <= '0;
         overflow <= 1'b0;
`ifdef BCD_SIGNED_EN
         neg_cap  <= 1'b0;
         neg      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sr      <= (BW+W)'(load_val);
                  cnt     <= CW'(W);
                  ovf     <= 1'b0;
`ifdef BCD_SIGNED_EN
                  neg_cap <= bin_in[W-1];
`endif
               end
            end
            S_SHIFT: begin
               sr  <= sr_shl;
               cnt <= cnt - CW'(1);
               ovf <= ovf | adj[BW-1];
               if (last) begin
                  bcd_out  <= sr_shl[BW+W-1:W];
                  overflow <= ovf | adj[BW-1];
`ifdef BCD_SIGNED_EN
                  neg      <= neg_cap;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
